// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with a 2-entry skid buffer.
// in_ready is driven from a flop, and control bits are zeroed whenever the stage holds a bubble.
module pipe_stage_reg #(
    parameter int unsigned        DATA_W   = 96,
    parameter int unsigned        CTRL_W   = 8,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // The encoding is {main_valid, skid_valid}; the value 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   main_data, main_data_nxt, skid_data, skid_data_nxt;
    logic [CTRL_W-1:0]   main_ctrl, main_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
    logic                main_valid, skid_valid, in_fire, out_fire;

    assign main_valid = state[1];
    assign skid_valid = state[0];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign out_data   = main_data;
    assign out_ctrl   = main_valid ? main_ctrl : '0;
    assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_nxt     = state;
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (flush) begin
            // The downstream side may still complete a transfer in this cycle, but nothing is captured from upstream.
            state_nxt     = EMPTY;
            main_ctrl_nxt = CTRL_RST;
            skid_ctrl_nxt = CTRL_RST;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                        state_nxt     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_nxt = in_data;
                        main_ctrl_nxt = in_ctrl;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end else if (in_fire) begin
                        skid_data_nxt = in_data;
                        skid_ctrl_nxt = in_ctrl;
                        state_nxt     = TWO;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_data_nxt = skid_data;
                        main_ctrl_nxt = skid_ctrl;
                        state_nxt     = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the data storage is reset along with the state so that it starts from a known value; non-blocking assignments throughout.
        if (!rstn) begin
            state     <= EMPTY;
            main_data <= '0;
            skid_data <= '0;
            main_ctrl <= CTRL_RST;
            skid_ctrl <= CTRL_RST;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            skid_data <= skid_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_ctrl <= skid_ctrl_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, stall/skid, flush, reset mid-stall, bubble gating.
// Inputs change #1 after each rising edge, and outputs are sampled at that same point.
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rstn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST('0)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    task automatic check_state(input string tag, input logic ov, input logic ir, input logic [1:0] occ);
        check({tag, ".out_valid"}, out_valid, ov);
        check({tag, ".in_ready"}, in_ready, ir);
        check({tag, ".occupancy"}, occupancy, occ);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 96'h5, 8'hFF);
        #1;
        step(); step();
        check_state("rst_hold", 1'b0, 1'b1, 2'd0);
        check("rst_hold.out_ctrl", out_ctrl, 8'h00);
        rstn = 1'b1;
        drive(1'b0, 96'h0, 8'h00);
        step();
        check_state("rst_rel", 1'b0, 1'b1, 2'd0);
        check("rst_rel.out_ctrl", out_ctrl, 8'h00);

        // Streaming: each beat appears one cycle after it is presented.
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, DATA_W'(i), CTRL_W'(i));
            step();
            check_state($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1);
            check($sformatf("stream%0d.out_data", i), out_data, 128'(i));
            check($sformatf("stream%0d.out_ctrl", i), out_ctrl, 128'(i));
        end
        drive(1'b0, 96'h0, 8'h00);
        step();
        check_state("drain", 1'b0, 1'b1, 2'd0);
        check("drain.out_ctrl", out_ctrl, 8'h00);
        check("drain.main_ctrl", dut.main_ctrl, 8'h0A);

        // Stall/skid: A, B, C back-to-back while downstream stalls.
        out_ready = 1'b0;
        drive(1'b1, 96'hA, 8'hA1);
        step();
        check_state("stallA", 1'b1, 1'b1, 2'd1);
        check("stallA.out_data", out_data, 96'hA);
        drive(1'b1, 96'hB, 8'hB2);
        step();
        check_state("stallB", 1'b1, 1'b0, 2'd2);
        check("stallB.out_data", out_data, 96'hA);
        check("stallB.out_ctrl", out_ctrl, 8'hA1);
        drive(1'b1, 96'hC, 8'hC3);
        step();
        check_state("stallC", 1'b1, 1'b0, 2'd2);
        check("stallC.out_data", out_data, 96'hA);
        check("stallC.out_ctrl", out_ctrl, 8'hA1);
        out_ready = 1'b1;
        step();
        check_state("promoteB", 1'b1, 1'b1, 2'd1);
        check("promoteB.out_data", out_data, 96'hB);
        check("promoteB.out_ctrl", out_ctrl, 8'hB2);
        step();
        check_state("passC", 1'b1, 1'b1, 2'd1);
        check("passC.out_data", out_data, 96'hC);
        check("passC.out_ctrl", out_ctrl, 8'hC3);
        drive(1'b0, 96'h0, 8'h00);
        step();
        check_state("emptyC", 1'b0, 1'b1, 2'd0);

        // Flush from TWO with an upstream beat present.
        out_ready = 1'b0;
        drive(1'b1, 96'h1A, 8'h11);
        step();
        drive(1'b1, 96'h1B, 8'h22);
        step();
        check_state("fill", 1'b1, 1'b0, 2'd2);
        flush = 1'b1;
        drive(1'b1, 96'h1D, 8'h44);
        step();
        flush = 1'b0;
        check_state("flush2", 1'b0, 1'b1, 2'd0);
        check("flush2.out_ctrl", out_ctrl, 8'h00);
        drive(1'b1, 96'h1E, 8'h55);
        step();
        check_state("pushE", 1'b1, 1'b1, 2'd1);
        check("pushE.out_data", out_data, 96'h1E);
        check("pushE.out_ctrl", out_ctrl, 8'h55);

        // Flush from ONE while in_ready=1: the offered beat must be ignored.
        flush = 1'b1;
        drive(1'b1, 96'h1F, 8'h66);
        step();
        flush = 1'b0;
        drive(1'b0, 96'h0, 8'h00);
        check_state("flush1", 1'b0, 1'b1, 2'd0);
        check("flush1.out_ctrl", out_ctrl, 8'h00);
        step();
        check_state("flush1_after", 1'b0, 1'b1, 2'd0);

        // Reset mid-stall drops both entries.
        drive(1'b1, 96'h2A, 8'h77);
        step();
        drive(1'b1, 96'h2B, 8'h88);
        step();
        check_state("fill2", 1'b1, 1'b0, 2'd2);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        drive(1'b0, 96'h0, 8'h00);
        check_state("rst_stall", 1'b0, 1'b1, 2'd0);
        check("rst_stall.out_ctrl", out_ctrl, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
